// File: rtl/shift_div_seq.sv
// Sequential unsigned restoring divider producing one quotient bit per clock,
// with a start/in_ready request handshake and an out_valid/out_ready result handshake.
module shift_div_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             in_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] a_next;

  // One restoring step: the trial carries an extra MSB so its sign says
  // whether the shifted partial remainder was at least the divisor.
  always_comb begin
    trial  = {r, a[WIDTH-1]} - {1'b0, d};
    q_bit  = ~trial[WIDTH];
    r_next = q_bit ? trial[WIDTH-1:0] : {r[WIDTH-2:0], a[WIDTH-1]};
    a_next = {a[WIDTH-2:0], q_bit};
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a         <= '0;
      d         <= '0;
      r         <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
              state     <= DONE;
            end else begin
              a        <= dividend;
              d        <= divisor;
              r        <= '0;
              count    <= '0;
              div_zero <= 1'b0;
              state    <= CALC;
            end
          end
        end
        CALC: begin
          a     <= a_next;
          r     <= r_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            quotient  <= a_next;
            remainder <= r_next;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            div_zero <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_div_seq.sv
// Self-checking bench for shift_div_seq: directed vector table, backpressure,
// mid-operation reset and a randomized sweep against a division reference.
module tb_shift_div_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       in_ready;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_zero;
  logic       out_valid;
  logic       out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  shift_div_seq #(.WIDTH(8), .CW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one request and wait for its result. lat counts clock edges from
  // the acceptance edge (inclusive) until out_valid is seen. The result is
  // captured on the first cycle out_valid is high, then the handshake is
  // completed after `hold` extra stall cycles (or immediately if rdy=1).
  task automatic run_op(input logic [7:0] dd, input logic [7:0] dv,
                        input logic rdy, input int hold,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output int lat, output bit ok);
    int guard;
    ok = 1'b1;
    q = '0; r = '0; dz = 1'b0; lat = 0;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      ok = 1'b0;
      return;
    end
    start     = 1'b1;
    dividend  = dd;
    divisor   = dv;
    out_ready = rdy;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      ok = 1'b0;
      return;
    end
    q  = quotient;
    r  = remainder;
    dz = div_zero;
    if (!rdy) begin
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q, r;
    logic       dz;
    int         lat;
    bit         ok;

    vecs[0] = '{dd: 8'd200, dv: 8'd7, q: 8'd28,  r: 8'd4,  dz: 1'b0, lat: 9};
    vecs[1] = '{dd: 8'd255, dv: 8'd1, q: 8'd255, r: 8'd0,  dz: 1'b0, lat: 9};
    vecs[2] = '{dd: 8'd5,   dv: 8'd9, q: 8'd0,   r: 8'd5,  dz: 1'b0, lat: 9};
    vecs[3] = '{dd: 8'd0,   dv: 8'd3, q: 8'd0,   r: 8'd0,  dz: 1'b0, lat: 9};
    vecs[4] = '{dd: 8'd77,  dv: 8'd0, q: 8'hFF,  r: 8'd77, dz: 1'b1, lat: 1};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b0;
    #12;
    check("reset_in_ready",  in_ready,  1);
    check("reset_out_valid", out_valid, 0);
    check("reset_div_zero",  div_zero,  0);
    check("reset_quotient",  quotient,  0);
    check("reset_remainder", remainder, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].dd, vecs[i].dv, 1'b0, 0, q, r, dz, lat, ok);
      if (ok) begin
        check($sformatf("vec%0d_quotient", i),  q,   vecs[i].q);
        check($sformatf("vec%0d_remainder", i), r,   vecs[i].r);
        check($sformatf("vec%0d_div_zero", i),  dz,  vecs[i].dz);
        check($sformatf("vec%0d_latency", i),   lat, vecs[i].lat);
      end
      check($sformatf("vec%0d_idle_after", i), in_ready, 1);
    end

    // Backpressure: result held, start pulses ignored while out_ready=0
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = 8'd9; divisor = 8'd2;
    begin
      int guard = 0;
      while (!out_valid && guard < 40) begin
        @(negedge clk);
        guard++;
      end
    end
    check("bp_out_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      start = (c % 2 == 0);
      dividend = 8'(c * 13);
      divisor  = 8'(c + 1);
      @(negedge clk);
      check($sformatf("bp%0d_quotient", c),  quotient,  14);
      check($sformatf("bp%0d_remainder", c), remainder, 2);
      check($sformatf("bp%0d_in_ready", c),  in_ready,  0);
      check($sformatf("bp%0d_out_valid", c), out_valid, 1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready",  in_ready,  1);
    check("bp_hold_quotient",     quotient,  14);

    // Reset during the fourth step of 144/12
    @(negedge clk);
    start = 1'b1; dividend = 8'd144; divisor = 8'd12;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  in_ready,  1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient",  quotient,  0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_zero",  div_zero,  0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_valid", out_valid, 0);
    end
    run_op(8'd144, 8'd12, 1'b0, 0, q, r, dz, lat, ok);
    if (ok) begin
      check("restart_quotient",  q, 12);
      check("restart_remainder", r, 0);
      check("restart_latency",   lat, 9);
    end

    // Random sweep with random out_ready behaviour
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] dd, dv;
      dd = 8'($urandom_range(0, 255));
      dv = (n % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      run_op(dd, dv, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             q, r, dz, lat, ok);
      if (!ok) break;
      if (dv == 0) begin
        check("rand_dz_quotient",  q,  255);
        check("rand_dz_remainder", r,  int'(dd));
        check("rand_dz_flag",      dz, 1);
      end else begin
        check("rand_quotient",  q, int'(dd) / int'(dv));
        check("rand_remainder", r, int'(dd) % int'(dv));
        check("rand_invariant", int'(q) * int'(dv) + int'(r), int'(dd));
        check("rand_dz_clear",  dz, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
